// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: sequencer state encoding and counter widths.
// Imported by pll_lock_supervisor; no logic lives here.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_sup_state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop single-bit synchroniser; q follows d after 2 clk edges.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rPLL reset/lock sequencer on the reference clock; gates the pixel-domain reset on stable lock.
// Optional lock_loss_cnt output when LOCK_LOSS_COUNTER_EN is defined; lock decisions lag pll_lock by 2 cycles.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 25,
  parameter int LOCK_TIMEOUT_CYCLES = 250000,
  parameter int LOCK_STABLE_CYCLES  = 2500,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               force_relock,
  output logic               pll_reset,
  output logic               user_rst,
  output logic               pll_ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef LOCK_LOSS_COUNTER_EN
  ,
  output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

  localparam int MAX_P = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES)
                       ? ((PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES)
                       : ((LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES);
  localparam int TW = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0]      LD_RST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]      LD_WAIT = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]      LD_STB  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W:0]   MAX_R   = (RETRY_W + 1)'(MAX_RETRIES);

  pll_sup_state_t     state, state_nxt;
  logic [TW-1:0]      timer, timer_nxt, timer_cur, timer_ld;
  logic               fresh;
  logic               expired;
  logic               reload;
  logic               lock_s;
  logic [RETRY_W:0]   retry_sum;
  logic [RETRY_W-1:0] retry_nxt;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    // The first cycle after reset is the first PLL_RST cycle, so treat the timer as freshly loaded.
    timer_cur = fresh ? LD_RST : timer;
    expired   = (timer_cur == '0);
    retry_sum = {1'b0, retry_cnt} + (RETRY_W + 1)'(1);

    if (force_relock) begin
      state_nxt = PLL_RST;
      retry_nxt = '0;
    end else begin
      case (state)
        PLL_RST:   if (expired) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (expired) begin
            // Fault decision uses the unsaturated count so MAX_RETRIES = 15 still terminates.
            retry_nxt = retry_sum[RETRY_W] ? '1 : retry_sum[RETRY_W-1:0];
            state_nxt = (retry_sum > MAX_R) ? FAULT : PLL_RST;
          end
        end
        STABLE: begin
          if (!lock_s)      state_nxt = WAIT_LOCK;
          else if (expired) state_nxt = RUN;
        end
        RUN:       if (!lock_s) state_nxt = PLL_RST;
        FAULT:     state_nxt = FAULT;
        default:   state_nxt = PLL_RST;
      endcase
    end

    if (state_nxt == RUN) retry_nxt = '0;

    reload = force_relock || (state_nxt != state);
    case (state_nxt)
      PLL_RST:   timer_ld = LD_RST;
      WAIT_LOCK: timer_ld = LD_WAIT;
      STABLE:    timer_ld = LD_STB;
      default:   timer_ld = '0;
    endcase
    timer_nxt = reload ? timer_ld : (expired ? '0 : timer_cur - TW'(1));
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= PLL_RST;
      timer     <= '0;
      fresh     <= 1'b1;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      user_rst  <= 1'b1;
      pll_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      fresh     <= 1'b0;
      retry_cnt <= retry_nxt;
      pll_reset <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
      user_rst  <= (state_nxt != RUN);
      pll_ready <= (state_nxt == RUN);
      fault     <= (state_nxt == FAULT);
    end
  end

`ifdef LOCK_LOSS_COUNTER_EN
  logic loss_evt;
  assign loss_evt = (state == RUN) && !lock_s && !force_relock;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_loss_cnt <= '0;
    end else if (loss_evt && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: an elapsed-time reference model predicts output changes.
// Directed lock/loss/glitch/fault/force/reset phases followed by randomized lock, force and reset traffic.
module tb_pll_lock_supervisor;

  localparam int PRC  = 4;
  localparam int TO   = 50;
  localparam int SC   = 20;
  localparam int MAXR = 2;
  localparam int NCYC = 3000;

  localparam int S_RST  = 0;
  localparam int S_WAIT = 1;
  localparam int S_STB  = 2;
  localparam int S_RUN  = 3;
  localparam int S_FLT  = 4;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_reset;
  logic       user_rst;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [15:0] llc_w;
  logic [23:0] dut_vec;

`ifdef LOCK_LOSS_COUNTER_EN
  logic [15:0] lock_loss_cnt;
  assign llc_w = lock_loss_cnt;
`else
  assign llc_w = 16'h0;
`endif

  assign dut_vec = {pll_reset, user_rst, pll_ready, fault, retry_cnt, llc_w};

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (SC),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .force_relock (force_relock),
    .pll_reset    (pll_reset),
    .user_rst     (user_rst),
    .pll_ready    (pll_ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
`ifdef LOCK_LOSS_COUNTER_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  // Stimulus per clock edge index, and the model's view of the block after that edge.
  bit lock_w  [NCYC];
  bit force_w [NCYC];
  bit rst_w   [NCYC];
  int st_a    [NCYC];
  int rc_a    [NCYC];
  int llc_a   [NCYC];

  typedef struct {
    int          cyc;
    logic [23:0] vec;
  } ev_t;

  ev_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  // Lock as seen by the decision logic: two edges late, forced low while the synchroniser is reset.
  function automatic bit lock_s_at(int k);
    if (k < 2) return 1'b0;
    if (rst_w[k-1] || rst_w[k-2]) return 1'b0;
    return lock_w[k-2];
  endfunction

  // Each state is described by how long it has been occupied (k - entry) against the spec'd windows.
  function automatic void run_model();
    int cur, entry, rc, llc, nxt;
    cur = S_RST; entry = 0; rc = 0; llc = 0;
    for (int k = 0; k < NCYC; k++) begin
      nxt = cur;
      if (rst_w[k]) begin
        nxt = S_RST; rc = 0; llc = 0;
      end else if (force_w[k]) begin
        nxt = S_RST; rc = 0;
      end else begin
        case (cur)
          S_RST: if (k - entry == PRC) nxt = S_WAIT;
          S_WAIT: begin
            if (lock_s_at(k)) nxt = S_STB;
            else if (k - entry == TO) begin
              nxt = (rc + 1 > MAXR) ? S_FLT : S_RST;
              rc  = (rc >= 15) ? 15 : rc + 1;
            end
          end
          S_STB: begin
            if (!lock_s_at(k))        nxt = S_WAIT;
            else if (k - entry == SC) nxt = S_RUN;
          end
          S_RUN: begin
            if (!lock_s_at(k)) begin
              nxt = S_RST;
              if (llc < 65535) llc++;
            end
          end
          default: ;
        endcase
      end
      if (nxt == S_RUN) rc = 0;
      if (rst_w[k] || force_w[k] || nxt != cur) entry = k;
      cur = nxt;
      st_a[k] = cur; rc_a[k] = rc; llc_a[k] = llc;
    end
  endfunction

  function automatic logic [23:0] exp_vec(int k);
    logic [3:0]  o;
    logic [15:0] l;
    l = 16'h0;
`ifdef LOCK_LOSS_COUNTER_EN
    l = 16'(llc_a[k]);
`endif
    case (st_a[k])
      S_RST:          o = 4'b1100;
      S_WAIT, S_STB:  o = 4'b0100;
      S_RUN:          o = 4'b0010;
      default:        o = 4'b1101;
    endcase
    return {o, 4'(rc_a[k]), l};
  endfunction

  // Driver: sets the inputs for edge k and queues the predicted output change at that edge.
  initial begin
    int  kf, ks, lvl, len, k;
    ev_t ev;

    for (int i = 0; i < NCYC; i++) begin
      rst_w[i]   = (i < 3);
      force_w[i] = 1'b0;
      lock_w[i]  = (i >= 16 && i <= 120) || (i >= 122 && i <= 135) ||
                   (i >= 137 && i <= 250) || (i >= 660 && i < 800);
    end
    force_w[450] = 1'b1;

    k = 800;
    lvl = 1;
    while (k < NCYC) begin
      len = lvl ? $urandom_range(1, 90) : $urandom_range(1, 70);
      for (int j = 0; j < len && k < NCYC; j++) begin
        lock_w[k]  = lvl[0];
        force_w[k] = ($urandom_range(0, 149) == 0);
        rst_w[k]   = ($urandom_range(0, 799) == 0);
        k++;
      end
      lvl = 1 - lvl;
    end

    // Align a force_relock with the edge where the final timeout would enter FAULT.
    run_model();
    kf = -1;
    for (int i = 451; i < 800; i++) if (kf < 0 && st_a[i] == S_FLT) kf = i;
    if (kf >= 0) force_w[kf] = 1'b1;
    run_model();

    // Synchronous reset part-way through the next STABLE window.
    ks = -1;
    for (int i = (kf >= 0 ? kf : 451); i < 780; i++) if (ks < 0 && st_a[i] == S_STB) ks = i;
    if (ks >= 0) rst_w[ks + 8] = 1'b1;
    run_model();

    for (int i = 0; i < NCYC; i++) begin
      if (i > 0) @(negedge clkin);
      reset        = rst_w[i];
      pll_lock     = lock_w[i];
      force_relock = force_w[i];
      if (i == 0 || exp_vec(i) !== exp_vec(i - 1)) begin
        ev.cyc = i;
        ev.vec = exp_vec(i);
        sb_q.push_back(ev);
      end
    end
  end

  // Monitor: every output change must match the oldest predicted change, on the same edge.
  initial begin
    logic [23:0] last;
    ev_t         ev;
    last = 'x;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clkin);
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc < k) begin
        ev = sb_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_change edge=%0d dut=%h expected=%h", ev.cyc, dut_vec, ev.vec);
      end
      if (dut_vec !== last) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change edge=%0d dut=%h expected=%h", k, dut_vec, last);
        end else begin
          ev = sb_q.pop_front();
          if (ev.cyc != k || ev.vec !== dut_vec) begin
            failures++;
            $display("FAIL output_change edge=%0d dut=%h expected=%h at edge %0d",
                     k, dut_vec, ev.vec, ev.cyc);
          end
        end
        last = dut_vec;
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
